// File: rtl/cordic16s_sched.sv
// Job scheduler for the 16-bit serial CORDIC: sample FIFO, NCO phase for rotate jobs,
// load/rdy handshake and result capture. Define CSCHED_WATCHDOG_EN to enable the rdy watchdog.
module cordic16s_sched #(
    parameter int AW  = 2,
    parameter int TMO = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din_i,
    input  logic [15:0] din_q,
    input  logic        din_mode,
    input  logic        din_stb,
    input  logic [15:0] freq,
    input  logic        ovf_clr,
    output logic [15:0] cx,
    output logic [15:0] cy,
    output logic [15:0] cz,
    output logic        cmode,
    output logic        cload,
    input  logic [15:0] cxo,
    input  logic [15:0] cyo,
    input  logic [15:0] czo,
    input  logic        crdy,
    input  logic        cmo,
    output logic [15:0] dout_x,
    output logic [15:0] dout_y,
    output logic [15:0] dout_z,
    output logic        dout_mode,
    output logic        dout_stb,
    output logic        busy,
    output logic        ovf,
    output logic        err
);
    localparam int DEPTH = 1 << AW;

    // The watchdog counter is 5 bits and the engine needs at least 20 clocks.
    if (TMO <= 20 || TMO > 32) begin : g_bad_tmo
        $error("cordic16s_sched: TMO must be in 21..32");
    end

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
    state_t state, state_nx;

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic [32:0]   cur;
    logic [15:0]   acc;
    logic          empty, full, pop, push, drop, cap, tmo;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign pop   = (state == IDLE) && !empty;
    // A full FIFO still accepts a sample when the head leaves in the same clock.
    assign push  = din_stb && (!full || pop);
    assign drop  = din_stb && full && !pop;
    assign busy  = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {din_mode, din_i, din_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            cur  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr <= rptr + 1'b1;
                cur  <= mem[rptr];
            end
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

`ifdef CSCHED_WATCHDOG_EN
    logic [4:0] wcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
            err  <= 1'b0;
        end else begin
            wcnt <= (state == WAIT) ? wcnt + 5'd1 : 5'd0;
            if (tmo) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: if (!empty) state_nx = LOAD;
            LOAD: state_nx = WAIT;
            WAIT: begin
                if (crdy) begin
                    cap      = 1'b1;
                    state_nx = IDLE;
                end
`ifdef CSCHED_WATCHDOG_EN
                // The counter would reach TMO on this edge: give up on the job.
                else if (wcnt == 5'(TMO - 1)) begin
                    tmo      = 1'b1;
                    state_nx = IDLE;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx        <= '0;
            cy        <= '0;
            cz        <= '0;
            cmode     <= 1'b0;
            cload     <= 1'b0;
            acc       <= '0;
            dout_x    <= '0;
            dout_y    <= '0;
            dout_z    <= '0;
            dout_mode <= 1'b0;
            dout_stb  <= 1'b0;
        end else begin
            cload    <= (state == LOAD);
            dout_stb <= cap;
            if (state == LOAD) begin
                cx    <= cur[31:16];
                cy    <= cur[15:0];
                cmode <= cur[32];
                cz    <= cur[32] ? acc : 16'd0;
                if (cur[32]) acc <= acc + freq;
            end
            if (cap) begin
                dout_x    <= cxo;
                dout_y    <= cyo;
                dout_z    <= czo;
                dout_mode <= cmo;
            end
        end
    end
endmodule

// File: tb/tb_cordic16s_sched.sv
// Directed bench for cordic16s_sched: a behavioural engine with fixed latency plus
// scoreboard queues for the load side and the result side.
module tb_cordic16s_sched;
    localparam int AW  = 2;
    localparam int TMO = 31;
    localparam int LAT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din_i, din_q, freq;
    logic        din_mode, din_stb, ovf_clr;
    logic [15:0] cx, cy, cz, cxo, cyo, czo;
    logic        cmode, cload, crdy, cmo;
    logic [15:0] dout_x, dout_y, dout_z;
    logic        dout_mode, dout_stb, busy, ovf, err;

    cordic16s_sched #(.AW(AW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .din_i(din_i), .din_q(din_q), .din_mode(din_mode),
        .din_stb(din_stb), .freq(freq), .ovf_clr(ovf_clr), .cx(cx), .cy(cy), .cz(cz),
        .cmode(cmode), .cload(cload), .cxo(cxo), .cyo(cyo), .czo(czo), .crdy(crdy),
        .cmo(cmo), .dout_x(dout_x), .dout_y(dout_y), .dout_z(dout_z),
        .dout_mode(dout_mode), .dout_stb(dout_stb), .busy(busy), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        m;
        logic [15:0] x, y, z;
    } job_t;

    job_t        exp_in[$], exp_out[$];
    job_t        eng_job;
    int          checks = 0, errors = 0;
    int          cyc = 0, loads = 0, douts = 0, load_cyc = 0;
    int          eng_cnt = 0;
    bit          eng_on = 1'b1, kick = 1'b0, kick_bogus = 1'b0;
    logic [15:0] acc_m = '0;

    function automatic job_t model(input job_t j);
        job_t r;
        r.x = j.x + 16'h1111;
        r.y = j.y ^ 16'h00ff;
        r.z = j.z - 16'h0101;
        r.m = j.m;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rdy(input job_t r);
        crdy = 1'b1;
        cxo  = r.x;
        cyo  = r.y;
        czo  = r.z;
        cmo  = r.m;
    endtask

    // Queue a sample; the expected cz follows the NCO with freq as it stands now.
    task automatic send(input logic m, input logic [15:0] i, input logic [15:0] q, input bit keep);
        job_t e;
        din_mode = m;
        din_i    = i;
        din_q    = q;
        din_stb  = 1'b1;
        if (keep) begin
            e.m = m; e.x = i; e.y = q;
            e.z = m ? acc_m : 16'd0;
            if (m) acc_m = acc_m + freq;
            exp_in.push_back(e);
        end
    endtask

    // One clock: engine model and monitor at the falling edge, stimulus after the rising edge.
    task automatic step();
        job_t e;
        @(negedge clk);
        cyc++;
        crdy = 1'b0;
        if (kick) begin
            kick = 1'b0;
            if (kick_bogus) drive_rdy({1'b1, 16'hdead, 16'hbeef, 16'hcafe});
            else            drive_rdy(model(eng_job));
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) drive_rdy(model(eng_job));
        end
        if (cload) begin
            eng_job = {cmode, cx, cy, cz};
            if (eng_on) eng_cnt = LAT;
            loads++;
            load_cyc = cyc;
            if (exp_in.size() == 0) chk("cload_unexpected", cload, 1'b0);
            else begin
                e = exp_in.pop_front();
                chk("cx", cx, e.x);
                chk("cy", cy, e.y);
                chk("cz", cz, e.z);
                chk("cmode", cmode, e.m);
                exp_out.push_back(model(e));
            end
        end
        if (dout_stb) begin
            douts++;
            if (exp_out.size() == 0) chk("dout_stb_unexpected", dout_stb, 1'b0);
            else begin
                e = exp_out.pop_front();
                chk("dout", {dout_mode, dout_x, dout_y, dout_z}, e);
            end
        end
        @(posedge clk);
        #1;
        din_stb = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {cx, cy, cz, cmode, cload, dout_x, dout_y, dout_z, dout_mode, dout_stb,
                  busy, ovf, err}, '0);
    endtask

    initial begin
        int d0, l0;
        logic [47:0] saved;
        rst = 1'b1; din_i = '0; din_q = '0; din_mode = 1'b0; din_stb = 1'b0;
        freq = '0; ovf_clr = 1'b0; crdy = 1'b0; cxo = '0; cyo = '0; czo = '0; cmo = 1'b0;
        #1;
        chk_zero("reset_outputs");
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1: rotate jobs, NCO steps by a quarter turn per job
        freq = 16'd16384;
        d0 = douts;
        for (int k = 0; k < 5; k++) begin
            send(1'b1, 16'd14142, 16'd0, 1'b1);
            step();
            repeat (20) step();
        end
        repeat (40) step();
        chk("t1_strobes", douts - d0, 5);
        chk("t1_acc", acc_m, 16'd16384);
        chk("t1_drain", exp_in.size() + exp_out.size(), 0);

        // 2: vector job leaves the NCO untouched; the next rotate job shows it
        freq = 16'd1234;
        send(1'b0, 16'd10000, 16'd10000, 1'b1);
        step();
        send(1'b1, 16'd100, 16'd200, 1'b1);
        step();
        repeat (60) step();
        chk("t2_drain", exp_in.size() + exp_out.size(), 0);

        // 3: engine stalled, six back-to-back samples; the last one is dropped even with ovf_clr
        eng_on = 1'b0;
        l0 = loads;
        for (int k = 0; k < 6; k++) begin
            send(1'b0, 16'(k * 7 + 1), 16'(k * 3 + 2), k < 5);
            if (k == 5) ovf_clr = 1'b1;
            step();
        end
        step();
        chk("t3_ovf_set", ovf, 1'b1);
        chk("t3_one_load", loads - l0, 1);
        chk("t3_busy", busy, 1'b1);
        ovf_clr = 1'b1;
        step();
        chk("t3_ovf_clr", ovf, 1'b0);
        eng_on = 1'b1;
        kick = 1'b1; kick_bogus = 1'b0;
        repeat (120) step();
        chk("t3_drain", exp_in.size() + exp_out.size(), 0);
        chk("t3_idle", busy, 1'b0);

`ifdef CSCHED_WATCHDOG_EN
        // 4: engine never answers; watchdog abandons the job and moves on
        eng_on = 1'b0;
        d0 = douts;
        l0 = loads;
        send(1'b0, 16'd11, 16'd22, 1'b1);
        step();
        send(1'b0, 16'd33, 16'd44, 1'b1);
        step();
        for (int k = 0; k < 80 && !err; k++) step();
        chk("t4_err", err, 1'b1);
        chk("t4_err_delay", cyc + 1 - load_cyc, TMO);
        exp_out.delete();
        eng_on = 1'b1;
        repeat (4) step();
        chk("t4_next_load", loads - l0, 2);
        chk("t4_next_delay", load_cyc - (cyc - 3 - TMO), TMO + 2);
        repeat (30) step();
        chk("t4_strobes", douts - d0, 1);
        chk("t4_drain", exp_in.size() + exp_out.size(), 0);
`else
        chk("err_tied", err, 1'b0);
`endif

        // 5: reset lands mid-job; the late crdy must be ignored and the NCO restarts at 0
        l0 = loads;
        freq = 16'd5000;
        send(1'b1, 16'd1000, 16'd2000, 1'b1);
        step();
        for (int k = 0; k < 10 && loads == l0; k++) step();
        chk("t5_load", loads - l0, 1);
        repeat (5) step();
        rst = 1'b1;
        exp_in.delete();
        exp_out.delete();
        acc_m = '0;
        #1;
        chk_zero("t5_reset_outputs");
        step();
        rst = 1'b0;
        d0 = douts;
        repeat (25) step();
        chk("t5_no_strobe", douts - d0, 0);
        send(1'b1, 16'd1234, 16'd4321, 1'b1);
        step();
        repeat (30) step();
        chk("t5_drain", exp_in.size() + exp_out.size(), 0);

        // 6: stray crdy while idle and empty
        saved = {dout_x, dout_y, dout_z};
        d0 = douts;
        kick = 1'b1; kick_bogus = 1'b1;
        repeat (4) step();
        chk("t6_dout_held", {dout_x, dout_y, dout_z}, saved);
        chk("t6_no_strobe", douts - d0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
